// File: rtl/sobel_pkg.sv
// sobel_pkg: window geometry shared by the window generator and the Sobel kernel stage.
package sobel_pkg;
  localparam int WIN_P = 3;
  function automatic int win_idx(input int i, input int j);
    return WIN_P * i + j;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one-row delay memory, combinational read and synchronous write at a shared index.
module line_buffer #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 640,
  localparam int IDX_W = $clog2(DEPTH_P)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [WIDTH_P-1:0] data_i,
  output logic [WIDTH_P-1:0] data_o
);
  logic [WIDTH_P-1:0] mem [DEPTH_P];
  always_ff @(posedge clk_i)
    if (we_i) mem[idx_i] <= data_i;
  assign data_o = mem[idx_i];
endmodule

// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3: streams raster pixels and emits one 3x3 window per accepted interior pixel.
module sobel_window_3x3
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = 8,
  parameter int IMG_W_P = 640,
  parameter int IMG_H_P = 480
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH_P-1:0]   data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [9*WIDTH_P-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);
  localparam int CW = $clog2(IMG_W_P);
  localparam int RW = $clog2(IMG_H_P);
  typedef logic [WIDTH_P-1:0] pix_t;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  pix_t lb0, lb1;
  pix_t [WIN_P-1:0][WIN_P-1:0] w_q;
  logic accept, col_end, row_end;
  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;
  assign col_end = col_q == CW'(IMG_W_P - 1);
  assign row_end = row_q == RW'(IMG_H_P - 1);
  // Packed layout puts w_q[i][j] at slice 3*i+j, matching the output format directly.
  assign data_o  = w_q;
  line_buffer #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P)) u_lb0 (
    .clk_i(clk_i), .we_i(accept), .idx_i(col_q), .data_i(data_i), .data_o(lb0)
  );
  line_buffer #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P)) u_lb1 (
    .clk_i(clk_i), .we_i(accept), .idx_i(col_q), .data_i(lb0), .data_o(lb1)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (accept) begin
      col_q   <= col_end ? '0 : col_q + 1'b1;
      if (col_end) row_q <= row_end ? '0 : row_q + 1'b1;
      w_q[0]  <= {lb1, w_q[0][2:1]};
      w_q[1]  <= {lb0, w_q[1][2:1]};
      w_q[2]  <= {data_i, w_q[2][2:1]};
      valid_o <= (row_q >= RW'(2)) && (col_q >= CW'(2));
      last_o  <= row_end & col_end;
    end else if (ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb_sobel_window_3x3: randomized and directed checks of the 3x3 window generator against an image model.
module tb_sobel_window_3x3;
  import sobel_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [7:0] a_din = 0, b_din = 0;
  logic a_vin = 0, b_vin = 0, a_rin = 1, b_rin = 1;
  logic a_ro, b_ro, a_vo, b_vo, a_lo, b_lo;
  logic [71:0] a_do, b_do;
  sobel_window_3x3 #(.WIDTH_P(8), .IMG_W_P(4), .IMG_H_P(4)) u_small (
    .clk_i(clk), .rst_i(rst), .data_i(a_din), .valid_i(a_vin), .ready_o(a_ro),
    .data_o(a_do), .valid_o(a_vo), .ready_i(a_rin), .last_o(a_lo)
  );
  sobel_window_3x3 #(.WIDTH_P(8), .IMG_W_P(640), .IMG_H_P(3)) u_wide (
    .clk_i(clk), .rst_i(rst), .data_i(b_din), .valid_i(b_vin), .ready_o(b_ro),
    .data_o(b_do), .valid_o(b_vo), .ready_i(b_rin), .last_o(b_lo)
  );
  typedef struct {logic [71:0] d; logic l;} win_t;
  win_t expq[$];
  logic [71:0] seen[$], basic_seen[$];
  logic [7:0] img [8][640];
  int mr, mc, n_win, n_last, checks, fails;
  bit prev_v, prev_acc;
  task automatic new_test();
    expq.delete();
    seen.delete();
    n_win = 0;
    n_last = 0;
  endtask
  task automatic step(input bit sel, input bit vin, input logic [7:0] din, input bit rin, output bit acc);
    int w = sel ? 640 : 4;
    int h = sel ? 3 : 4;
    logic v, l, ro;
    logic [71:0] d;
    win_t e;
    if (sel) begin b_vin = vin; b_din = din; b_rin = rin; end
    else begin a_vin = vin; a_din = din; a_rin = rin; end
    #1;
    v = sel ? b_vo : a_vo;
    l = sel ? b_lo : a_lo;
    ro = sel ? b_ro : a_ro;
    d = sel ? b_do : a_do;
    checks++;
    if (v !== (expq.size() != 0)) begin
      fails++;
      $display("FAIL valid_o: got %b want %b (pos %0d,%0d)", v, expq.size() != 0, mr, mc);
    end
    checks++;
    if (v === 1'b1 && !prev_v && !prev_acc) begin
      fails++;
      $display("FAIL valid_rise: valid_o rose without a preceding accept");
    end
    if (v === 1'b1 && expq.size() != 0) begin
      e = expq[0];
      checks++;
      if (d !== e.d) begin
        fails++;
        $display("FAIL window: got %h want %h", d, e.d);
      end
      checks++;
      if (l !== e.l) begin
        fails++;
        $display("FAIL last_o: got %b want %b", l, e.l);
      end
      if (rin) begin
        void'(expq.pop_front());
        seen.push_back(d);
        n_win++;
        if (l) n_last++;
      end
    end
    checks++;
    if (v === 1'b1 && !rin) begin
      if (ro !== 1'b0) begin
        fails++;
        $display("FAIL ready_o_stall: got %b want 0", ro);
      end
    end else if (ro !== 1'b1) begin
      fails++;
      $display("FAIL ready_o: got %b want 1", ro);
    end
    acc = vin && (ro === 1'b1);
    if (acc) begin
      img[mr][mc] = din;
      if (mr >= 2 && mc >= 2) begin
        e.d = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.d[8*win_idx(i, j) +: 8] = img[mr-2+i][mc-2+j];
        e.l = (mr == h - 1) && (mc == w - 1);
        expq.push_back(e);
      end
      mc++;
      if (mc == w) begin
        mc = 0;
        mr++;
        if (mr == h) mr = 0;
      end
    end
    prev_v = (v === 1'b1);
    prev_acc = acc;
    @(negedge clk);
  endtask
  task automatic drain(input bit sel);
    bit acc;
    repeat (4) step(sel, 1'b0, 8'h00, 1'b1, acc);
  endtask
  task automatic run_frame(input bit sel, input bit rnd);
    bit acc;
    int w = sel ? 640 : 4;
    int h = sel ? 3 : 4;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        step(sel, 1'b1, rnd ? 8'($urandom) : 8'(16 * r + c), 1'b1, acc);
        checks++;
        if (!acc) begin
          fails++;
          $display("FAIL full_rate_accept: pixel (%0d,%0d) not accepted", r, c);
        end
      end
  endtask
  task automatic check_counts(input string name, input int want_win, input int want_last);
    checks++;
    if (n_win != want_win) begin
      fails++;
      $display("FAIL %s_windows: got %0d want %0d", name, n_win, want_win);
    end
    checks++;
    if (n_last != want_last) begin
      fails++;
      $display("FAIL %s_last: got %0d want %0d", name, n_last, want_last);
    end
  endtask
  task automatic test_reset();
    bit acc;
    @(negedge clk);
    checks += 4;
    if (a_vo !== 1'b0 || a_lo !== 1'b0 || a_ro !== 1'b1 || a_do !== '0) begin
      fails++;
      $display("FAIL reset_state: valid %b last %b ready %b data %h", a_vo, a_lo, a_ro, a_do);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    mr = 0; mc = 0; prev_v = 0; prev_acc = 0;
    new_test();
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 8'(16 * (k / 4) + k % 4), 1'b1, acc);
    #2 rst = 1;
    #1;
    checks++;
    if (a_vo !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b want 0", a_vo); end
    checks++;
    if (a_lo !== 1'b0) begin fails++; $display("FAIL midreset_last: got %b want 0", a_lo); end
    checks++;
    if (a_ro !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", a_ro); end
    checks++;
    if (a_do !== '0) begin fails++; $display("FAIL midreset_data: got %h want 0", a_do); end
    @(negedge clk);
    rst = 0;
    mr = 0; mc = 0; prev_v = 0; prev_acc = 0;
    new_test();
    run_frame(1'b0, 1'b1);
    drain(1'b0);
    check_counts("after_reset", 4, 1);
  endtask
  task automatic test_basic();
    logic [71:0] f;
    new_test();
    run_frame(1'b0, 1'b0);
    drain(1'b0);
    check_counts("basic", 4, 1);
    basic_seen = seen;
    checks++;
    if (seen.size() == 4) begin
      f = seen[0];
      if (f[8*win_idx(0,0) +: 8] !== 8'h00 || f[8*win_idx(0,1) +: 8] !== 8'h01 ||
          f[8*win_idx(1,1) +: 8] !== 8'h11 || f[8*win_idx(2,2) +: 8] !== 8'h22) begin
        fails++;
        $display("FAIL basic_first_window: got %h want w00=00 w01=01 w11=11 w22=22", f);
      end
      checks++;
      f = seen[3];
      if (f[8*win_idx(2,2) +: 8] !== 8'h33) begin
        fails++;
        $display("FAIL basic_last_window: got w22=%h want 33", f[8*win_idx(2,2) +: 8]);
      end
    end else begin
      fails++;
      $display("FAIL basic_first_window: got %0d windows want 4", seen.size());
    end
  endtask
  task automatic test_backpressure();
    bit acc, did;
    int pi, stall;
    new_test();
    pi = 0; stall = 0; did = 0;
    for (int k = 0; k < 100 && pi < 16; k++) begin
      if (expq.size() != 0 && !did) begin stall = 3; did = 1; end
      step(1'b0, 1'b1, 8'(16 * (pi / 4) + pi % 4), stall == 0, acc);
      if (stall > 0) stall--;
      if (acc) pi++;
    end
    checks++;
    if (pi != 16) begin fails++; $display("FAIL bp_pixels: got %0d want 16", pi); end
    drain(1'b0);
    check_counts("backpressure", 4, 1);
    for (int i = 0; i < 4 && i < seen.size() && i < basic_seen.size(); i++) begin
      checks++;
      if (seen[i] !== basic_seen[i]) begin
        fails++;
        $display("FAIL bp_sequence[%0d]: got %h want %h", i, seen[i], basic_seen[i]);
      end
    end
  endtask
  task automatic test_bubbles();
    bit acc;
    int pi;
    new_test();
    pi = 0;
    for (int k = 0; k < 1000 && pi < 32; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0, acc);
      if (acc) pi++;
    end
    checks++;
    if (pi != 32) begin fails++; $display("FAIL bubbles_pixels: got %0d want 32", pi); end
    drain(1'b0);
    check_counts("bubbles", 8, 2);
  endtask
  task automatic test_back_to_back();
    logic [71:0] f;
    new_test();
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);
    drain(1'b0);
    check_counts("b2b", 8, 2);
    checks++;
    if (seen.size() == 8) begin
      f = seen[4];
      if (f[8*win_idx(0,0) +: 8] !== 8'h00 || f[8*win_idx(2,2) +: 8] !== 8'h22) begin
        fails++;
        $display("FAIL b2b_frame2_first: got %h want w00=00 w22=22", f);
      end
    end else begin
      fails++;
      $display("FAIL b2b_frame2_first: got %0d windows want 8", seen.size());
    end
  endtask
  task automatic test_row_wrap();
    new_test();
    run_frame(1'b1, 1'b1);
    drain(1'b1);
    check_counts("row_wrap", 638, 1);
  endtask
  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_row_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
